// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared control types for the pipelined RV32I control unit:
// ALU/WB encodings, opcodes, per-stage control bundles, helpers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SLL    = 4'd1,
        ALU_SLT    = 4'd2,
        ALU_SLTU   = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SRL    = 4'd5,
        ALU_SRA    = 4'd6,
        ALU_OR     = 4'd7,
        ALU_AND    = 4'd8,
        ALU_SUB    = 4'd9,
        ALU_MUL    = 4'd10,
        ALU_MULH   = 4'd11,
        ALU_MULHSU = 4'd12,
        ALU_MULHU  = 4'd13,
        ALU_DIV    = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        sel_a;
        logic        sel_b;
        logic [2:0]  br_type;
        logic        is_jump;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ex_ctrl_t;

    typedef struct packed {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  mask;
    } mem_ctrl_t;

    typedef struct packed {
        logic        reg_wr;
        wb_sel_e     sel;
        logic [4:0]  rd;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t    ex;
        mem_ctrl_t   mem;
        wb_ctrl_t    wb;
    } ctrl_bundle_t;

    // sub only exists for register-register ops
    function automatic alu_op_e f3_op(
        input logic [2:0] f3,
        input logic       alt,
        input logic       is_reg
    );
        alu_op_e op;
        case (f3)
            3'd0:    op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic is_m_op(input alu_op_e op);
        return op >= ALU_MUL;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-side handshake and per-stage control outputs of the control unit.
// master: IF/ID + datapath side; slave: pipe_ctrl_unit.
interface pipe_ctrl_if;
    logic        if_id_valid;
    logic [31:0] instr_id;
    logic        br_taken_ex;
    logic        id_ready;
    logic        flush_if_id;
    logic        illegal_instr;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic        ex_sel_A;
    logic        ex_sel_B;
    logic [2:0]  ex_br_type;
    logic        ex_is_jump;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        mem_valid;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [2:0]  mem_mask;
    logic [4:0]  mem_rd;
    logic        wb_valid;
    logic        wb_reg_wr;
    logic [1:0]  wb_sel;
    logic [4:0]  wb_rd;

    modport master (
        output if_id_valid, instr_id, br_taken_ex,
        input  id_ready, flush_if_id, illegal_instr,
        input  ex_valid, ex_alu_op, ex_sel_A, ex_sel_B,
        input  ex_br_type, ex_is_jump, ex_rs1, ex_rs2, ex_rd,
        input  mem_valid, mem_rd_en, mem_wr_en, mem_mask, mem_rd,
        input  wb_valid, wb_reg_wr, wb_sel, wb_rd
    );

    modport slave (
        input  if_id_valid, instr_id, br_taken_ex,
        output id_ready, flush_if_id, illegal_instr,
        output ex_valid, ex_alu_op, ex_sel_A, ex_sel_B,
        output ex_br_type, ex_is_jump, ex_rs1, ex_rs2, ex_rd,
        output mem_valid, mem_rd_en, mem_wr_en, mem_mask, mem_rd,
        output wb_valid, wb_reg_wr, wb_sel, wb_rd
    );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational RV32I(+M) decoder: instr -> ctrl_bundle_t, illegal.
// Ports: instr in, ctrl/illegal out. Unused fields stay zero.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic         illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        unique case (opc)
            OP_LUI: begin
                // rs1 left at x0 so the ALU computes 0 + imm
                ctrl.ex.sel_b = 1'b1;
                ctrl.wb.reg_wr = 1'b1;
                ctrl.wb.rd = instr[11:7];
            end
            OP_AUIPC: begin
                ctrl.ex.sel_a = 1'b1;
                ctrl.ex.sel_b = 1'b1;
                ctrl.wb.reg_wr = 1'b1;
                ctrl.wb.rd = instr[11:7];
            end
            OP_JAL: begin
                ctrl.ex.sel_a = 1'b1;
                ctrl.ex.sel_b = 1'b1;
                ctrl.ex.is_jump = 1'b1;
                ctrl.wb.reg_wr = 1'b1;
                ctrl.wb.sel = WB_PC4;
                ctrl.wb.rd = instr[11:7];
            end
            OP_JALR: begin
                illegal = (f3 != 3'd0);
                ctrl.ex.sel_b = 1'b1;
                ctrl.ex.is_jump = 1'b1;
                ctrl.ex.rs1 = instr[19:15];
                ctrl.wb.reg_wr = 1'b1;
                ctrl.wb.sel = WB_PC4;
                ctrl.wb.rd = instr[11:7];
            end
            OP_BRANCH: begin
                illegal = (f3 == 3'd2) || (f3 == 3'd3);
                ctrl.ex.sel_a = 1'b1;
                ctrl.ex.sel_b = 1'b1;
                ctrl.ex.br_type = f3;
                ctrl.ex.rs1 = instr[19:15];
                ctrl.ex.rs2 = instr[24:20];
            end
            OP_LOAD: begin
                illegal = (f3 == 3'd3) || (f3 > 3'd5);
                ctrl.ex.sel_b = 1'b1;
                ctrl.ex.rs1 = instr[19:15];
                ctrl.mem.rd_en = 1'b1;
                ctrl.mem.mask = f3;
                ctrl.wb.reg_wr = 1'b1;
                ctrl.wb.sel = WB_MEM;
                ctrl.wb.rd = instr[11:7];
            end
            OP_STORE: begin
                illegal = (f3 > 3'd2);
                ctrl.ex.sel_b = 1'b1;
                ctrl.ex.rs1 = instr[19:15];
                ctrl.ex.rs2 = instr[24:20];
                ctrl.mem.wr_en = 1'b1;
                ctrl.mem.mask = f3;
            end
            OP_IMM: begin
                illegal = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                          ((f3 == 3'd5) && (f7 != 7'h00) &&
                           (f7 != 7'h20));
                ctrl.ex.alu_op = f3_op(f3, f7[5], 1'b0);
                ctrl.ex.sel_b = 1'b1;
                ctrl.ex.rs1 = instr[19:15];
                ctrl.wb.reg_wr = 1'b1;
                ctrl.wb.rd = instr[11:7];
            end
            OP_REG: begin
                ctrl.ex.rs1 = instr[19:15];
                ctrl.ex.rs2 = instr[24:20];
                ctrl.wb.reg_wr = 1'b1;
                ctrl.wb.rd = instr[11:7];
                if (f7 == 7'h00 || (f7 == 7'h20 &&
                    (f3 == 3'd0 || f3 == 3'd5))) begin
                    ctrl.ex.alu_op = f3_op(f3, f7[5], 1'b1);
                end else if (EN_M && f7 == 7'h01) begin
                    ctrl.ex.alu_op = f3[2] ? ALU_DIV :
                        alu_op_e'(4'd10 + {2'b00, f3[1:0]});
                    ctrl.ex.br_type = f3;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_FENCE: ;
            default: illegal = 1'b1;
        endcase
        if (illegal) ctrl = '0;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Control unit: ID decode, EX/MEM/WB control registers, load-use
// stall, branch flush and M-extension hold. Ports: clk, rst_n, bus.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter bit          EN_M    = 1'b1,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_MWAIT = 1'b1;
    localparam int CW = $clog2(MUL_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

    ctrl_bundle_t  dec;
    logic          dec_ill;
    ctrl_bundle_t  ex_q;
    mem_ctrl_t     mem_m_q;
    wb_ctrl_t      mem_w_q;
    wb_ctrl_t      wb_q;
    logic          ex_v, mem_v, wb_v;
    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          in_mwait, hold, flush, load_use, take, m_in;

    ctrl_decode #(.EN_M(EN_M)) u_dec (
        .instr   (bus.instr_id),
        .ctrl    (dec),
        .illegal (dec_ill)
    );

    // the final MWAIT cycle (cnt==0) behaves like RUN so EX drains
    assign in_mwait = (state == S_MWAIT);
    assign hold     = in_mwait && (cnt != '0);
    assign flush    = bus.br_taken_ex && !in_mwait;
    // unused source fields are zero and rd!=0, so no match on x0
    assign load_use = ex_v && ex_q.mem.rd_en &&
                      (ex_q.wb.rd != 5'd0) && bus.if_id_valid &&
                      ((ex_q.wb.rd == dec.ex.rs1) ||
                       (ex_q.wb.rd == dec.ex.rs2));
    assign take = bus.if_id_valid && !dec_ill && !flush &&
                  !hold && !load_use;
    assign m_in = take && is_m_op(dec.ex.alu_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v    <= 1'b0;
            ex_q    <= '0;
            mem_v   <= 1'b0;
            mem_m_q <= '0;
            mem_w_q <= '0;
            wb_v    <= 1'b0;
            wb_q    <= '0;
            state   <= S_RUN;
            cnt     <= '0;
        end else begin
            wb_v <= mem_v;
            wb_q <= mem_w_q;
            if (hold) begin
                mem_v   <= 1'b0;
                mem_m_q <= '0;
                mem_w_q <= '0;
                cnt     <= cnt - 1'b1;
            end else begin
                mem_v   <= ex_v;
                mem_m_q <= ex_q.mem;
                mem_w_q <= ex_q.wb;
                ex_v    <= take;
                ex_q    <= take ? dec : '0;
                state   <= m_in ? S_MWAIT : S_RUN;
                cnt     <= m_in ? CNT_LOAD : '0;
            end
        end
    end

    assign bus.id_ready      = rst_n & ~hold & ~load_use;
    assign bus.flush_if_id   = rst_n & flush;
    assign bus.illegal_instr = rst_n & bus.if_id_valid & dec_ill;

    assign bus.ex_valid   = ex_v;
    assign bus.ex_alu_op  = ex_q.ex.alu_op;
    assign bus.ex_sel_A   = ex_q.ex.sel_a;
    assign bus.ex_sel_B   = ex_q.ex.sel_b;
    assign bus.ex_br_type = ex_q.ex.br_type;
    assign bus.ex_is_jump = ex_q.ex.is_jump;
    assign bus.ex_rs1     = ex_q.ex.rs1;
    assign bus.ex_rs2     = ex_q.ex.rs2;
    assign bus.ex_rd      = ex_q.wb.rd;

    assign bus.mem_valid  = mem_v;
    assign bus.mem_rd_en  = mem_m_q.rd_en;
    assign bus.mem_wr_en  = mem_m_q.wr_en;
    assign bus.mem_mask   = mem_m_q.mask;
    assign bus.mem_rd     = mem_w_q.rd;

    assign bus.wb_valid   = wb_v;
    assign bus.wb_reg_wr  = wb_q.reg_wr;
    assign bus.wb_sel     = wb_q.sel;
    assign bus.wb_rd      = wb_q.rd;

    // a taken branch cannot be in EX while an M op occupies it
    a_no_br_in_mwait: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(bus.br_taken_ex && in_mwait)
    );

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed instruction vectors,
// expected WB results queued at issue, checked by a WB monitor.
module tb_pipe_ctrl_unit;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW5   = 32'h0000A283;
    localparam logic [31:0] I_ADD6  = 32'h00228333;
    localparam logic [31:0] I_LW0   = 32'h0000A003;
    localparam logic [31:0] I_ADD60 = 32'h00200333;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_MUL   = 32'h022083B3;

    typedef struct packed {
        logic [4:0] rd;
        logic [1:0] sel;
        logic       wr;
    } wb_exp_t;

    logic    clk = 1'b0;
    logic    rst_n;
    int      n_vec = 0;
    int      n_err = 0;
    wb_exp_t q[$];
    wb_exp_t e;

    pipe_ctrl_if bus0();
    pipe_ctrl_if bus1();

    pipe_ctrl_unit #(.EN_M(1'b1), .MUL_LAT(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    pipe_ctrl_unit #(.EN_M(1'b0), .MUL_LAT(3)) u_nom (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus1.if_id_valid = bus0.if_id_valid;
    assign bus1.instr_id    = bus0.instr_id;
    assign bus1.br_taken_ex = bus0.br_taken_ex;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus0.if_id_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic push(input logic [4:0] rd, input logic [1:0] sel,
                        input logic wr);
        q.push_back('{rd: rd, sel: sel, wr: wr});
    endtask

    always @(negedge clk) begin
        if (rst_n && bus0.wb_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_unexpected: got rd %0d expected none",
                         bus0.wb_rd);
            end else begin
                e = q.pop_front();
                chk("wb_rd", bus0.wb_rd, e.rd);
                chk("wb_sel", bus0.wb_sel, e.sel);
                chk("wb_reg_wr", bus0.wb_reg_wr, e.wr);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus0.if_id_valid = 1'b0;
        bus0.instr_id = 32'h0;
        bus0.br_taken_ex = 1'b0;
        repeat (2) step();
        chk("rst_ex_valid", bus0.ex_valid, 0);
        chk("rst_mem_valid", bus0.mem_valid, 0);
        chk("rst_wb_valid", bus0.wb_valid, 0);
        chk("rst_id_ready", bus0.id_ready, 0);
        chk("rst_flush", bus0.flush_if_id, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_id_ready", bus0.id_ready, 1);

        // add x3,x1,x2 through all stages
        bus0.if_id_valid = 1'b1;
        bus0.instr_id = I_ADD;
        #1;
        chk("add_illegal", bus0.illegal_instr, 0);
        push(5'd3, 2'd0, 1'b1);
        step();
        chk("add_ex_valid", bus0.ex_valid, 1);
        chk("add_alu_op", bus0.ex_alu_op, 0);
        chk("add_rs1", bus0.ex_rs1, 1);
        chk("add_rs2", bus0.ex_rs2, 2);
        chk("add_sel_B", bus0.ex_sel_B, 0);
        bus0.if_id_valid = 1'b0;
        step();
        chk("add_mem_rd", bus0.mem_rd, 3);
        step();
        chk("add_wb_valid", bus0.wb_valid, 1);
        chk("add_wb_rd", bus0.wb_rd, 3);
        idle(1);

        // lw x5 then dependent add x6,x5,x2
        bus0.if_id_valid = 1'b1;
        bus0.instr_id = I_LW5;
        push(5'd5, 2'd1, 1'b1);
        step();
        bus0.instr_id = I_ADD6;
        #1;
        chk("lu_id_ready_low", bus0.id_ready, 0);
        step();
        chk("lu_bubble", bus0.ex_valid, 0);
        chk("lw_mem_rd_en", bus0.mem_rd_en, 1);
        chk("lw_mem_mask", bus0.mem_mask, 2);
        chk("lw_mem_rd", bus0.mem_rd, 5);
        #1;
        chk("lu_id_ready_back", bus0.id_ready, 1);
        push(5'd6, 2'd0, 1'b1);
        step();
        chk("lu_add_ex_valid", bus0.ex_valid, 1);
        chk("lu_add_rs1", bus0.ex_rs1, 5);
        idle(3);

        // lw x0 then add x6,x0,x2: no stall
        bus0.if_id_valid = 1'b1;
        bus0.instr_id = I_LW0;
        push(5'd0, 2'd1, 1'b1);
        step();
        bus0.instr_id = I_ADD60;
        #1;
        chk("x0_no_stall", bus0.id_ready, 1);
        push(5'd6, 2'd0, 1'b1);
        step();
        chk("x0_add_ex_valid", bus0.ex_valid, 1);
        chk("x0_add_rd", bus0.ex_rd, 6);
        idle(3);

        // beq taken in EX flushes the wrong-path instruction
        bus0.if_id_valid = 1'b1;
        bus0.instr_id = I_BEQ;
        push(5'd0, 2'd0, 1'b0);
        step();
        chk("beq_sel_A", bus0.ex_sel_A, 1);
        chk("beq_rs2", bus0.ex_rs2, 2);
        bus0.instr_id = I_ADD;
        bus0.br_taken_ex = 1'b1;
        #1;
        chk("beq_flush", bus0.flush_if_id, 1);
        step();
        bus0.br_taken_ex = 1'b0;
        chk("flush_bubble", bus0.ex_valid, 0);
        bus0.instr_id = I_JAL;
        push(5'd1, 2'd2, 1'b1);
        step();
        chk("jal_is_jump", bus0.ex_is_jump, 1);
        idle(3);

        // mul x7,x1,x2 with MUL_LAT=3
        bus0.if_id_valid = 1'b1;
        bus0.instr_id = I_MUL;
        #1;
        chk("mul_id_ready", bus0.id_ready, 1);
        chk("nom_mul_illegal", bus1.illegal_instr, 1);
        push(5'd7, 2'd0, 1'b1);
        step();
        chk("mul_alu_op", bus0.ex_alu_op, 10);
        chk("nom_mul_bubble", bus1.ex_valid, 0);
        bus0.instr_id = I_ADD;
        #1;
        chk("mul_wait1_ready", bus0.id_ready, 0);
        step();
        chk("mul_wait2_ex_valid", bus0.ex_valid, 1);
        chk("mul_wait2_mem", bus0.mem_valid, 0);
        chk("mul_wait2_ready", bus0.id_ready, 0);
        step();
        chk("mul_last_alu_op", bus0.ex_alu_op, 10);
        chk("mul_last_mem", bus0.mem_valid, 0);
        chk("mul_last_ready", bus0.id_ready, 1);
        push(5'd3, 2'd0, 1'b1);
        step();
        chk("mul_mem_valid", bus0.mem_valid, 1);
        chk("mul_mem_rd", bus0.mem_rd, 7);
        chk("after_mul_ex_rd", bus0.ex_rd, 3);
        bus0.if_id_valid = 1'b0;
        step();
        chk("mul_once_mem_rd", bus0.mem_rd, 3);
        idle(3);

        // reset in the 2nd MWAIT cycle aborts the mul
        bus0.if_id_valid = 1'b1;
        bus0.instr_id = I_MUL;
        step();
        bus0.if_id_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ex_valid", bus0.ex_valid, 0);
        chk("abort_alu_op", bus0.ex_alu_op, 0);
        chk("abort_id_ready", bus0.id_ready, 0);
        chk("abort_mem_valid", bus0.mem_valid, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("abort_run_ready", bus0.id_ready, 1);
        idle(6);
        chk("sb_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
